// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, the x0 select and the writeback entry layout for the RegFile port set
package regfile_pkg;
  localparam int RF_DATA_WIDTH = 32;
  localparam int RF_ADDR_WIDTH = 5;
  localparam int ZERO_REG = 0;
  typedef struct packed {
    logic [RF_ADDR_WIDTH-1:0] sel;
    logic [RF_DATA_WIDTH-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_fifo.sv
// regfile_wb_fifo: sync FIFO exposing every slot plus a valid mask so readers can search pending writes
module regfile_wb_fifo import regfile_pkg::*; #(
  parameter type entry_t = wb_entry_t,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  entry_t        push_entry,
  output entry_t        head_entry,
  output entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid,
  output logic [PW-1:0] head,
  output logic          full,
  output logic          empty
);
  logic [PW-1:0] tail;
  logic [PW:0] count;
  entry_t mem [DEPTH];
  always_ff @(posedge clock) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_entry;
        tail <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // a slot is live when its distance from head is below the occupancy
  always_comb begin
    valid = '0;
    for (int j = 0; j < DEPTH; j++) valid[j] = {1'b0, PW'(j) - head} < count;
  end
  assign entries = mem;
  assign head_entry = mem[head];
  assign full = count == (PW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: buffers writebacks ahead of the RegFile write port and forwards pending data to operand reads
module regfile_wb_queue import regfile_pkg::*; #(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ADDR_WIDTH-1:0] wb_sel,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_sel1,
  input  logic [ADDR_WIDTH-1:0] rd_sel2,
  output logic                  rd_rsp_valid,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  output logic                  idle,
  output logic                  rf_write,
  output logic [ADDR_WIDTH-1:0] rf_write_sel,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [ADDR_WIDTH-1:0] rf_read1_sel,
  output logic [ADDR_WIDTH-1:0] rf_read2_sel,
  input  logic [DATA_WIDTH-1:0] rf_read_data1,
  input  logic [DATA_WIDTH-1:0] rf_read_data2
);
  localparam int PW = $clog2(DEPTH);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] sel;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;
  entry_t wb_entry, head_entry;
  entry_t entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0] head;
  logic full, empty, accept, enq;
  logic [DATA_WIDTH-1:0] fwd1, fwd2;
  assign wb_ready = !full;
  assign accept = wb_valid & wb_ready;
  assign enq = accept && wb_sel != ADDR_WIDTH'(ZERO_REG);
  assign wb_entry = {wb_sel, wb_data};
  regfile_wb_fifo #(.entry_t(entry_t), .DEPTH(DEPTH)) fifo (
    .clock(clock), .reset(reset), .push(enq), .pop(!empty), .push_entry(wb_entry),
    .head_entry(head_entry), .entries(entries), .valid(valid), .head(head),
    .full(full), .empty(empty)
  );
  assign idle = empty;
  assign rf_write = !empty;
  assign rf_write_sel = head_entry.sel;
  assign rf_write_data = head_entry.data;
  assign rf_read1_sel = rd_sel1;
  assign rf_read2_sel = rd_sel2;
  // walk oldest to youngest so the youngest match overrides; same-cycle writeback beats the queue
  function automatic logic [DATA_WIDTH-1:0] lookup(input logic [ADDR_WIDTH-1:0] sel,
                                                   input logic [DATA_WIDTH-1:0] rf);
    logic [DATA_WIDTH-1:0] v;
    logic [PW-1:0] idx;
    v = rf;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && entries[idx].sel == sel) v = entries[idx].data;
    end
    if (accept && wb_sel == sel) v = wb_data;
    return sel == ADDR_WIDTH'(ZERO_REG) ? '0 : v;
  endfunction
  always_comb begin
    fwd1 = lookup(rd_sel1, rf_read_data1);
    fwd2 = lookup(rd_sel2, rf_read_data2);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_rsp_valid <= 1'b0;
      rd_data1 <= '0;
      rd_data2 <= '0;
    end else begin
      rd_rsp_valid <= rd_valid;
      if (rd_valid) begin
        rd_data1 <= fwd1;
        rd_data2 <= fwd2;
      end
    end
  end
endmodule
